accum: RTL and testbench
========================

Name: accum

Overview:
- Streaming accumulator placed directly downstream of the multiplier stage.
- Consumes a stream of products on a dti consumer interface.
- Sums each group of LEN consecutive transfers and emits one registered sum per group on a dti producer interface.
- Together with the multiplier it forms the MAC path used for dot-product and FIR-style datapaths.

Parameters:
DIN, 16, width of din.data (product width from the multiplier)
DIN_SIGNED, 0, 1 = din.data is two's complement and is sign-extended; 0 = zero-extended
LEN, 4, number of din transfers summed per output; legal range 1..65535
DOUT, DIN + $clog2(LEN), width of dout.data; sum arithmetic is signed iff DIN_SIGNED

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset; synchronous, active-low (asserted when 0)
din  dti.consumer  DIN (data) + valid/ready  product stream in
dout  dti.producer  DOUT (data) + valid/ready  accumulated sum out

Behaviour:
- Handshake
  - A transfer occurs on a port when valid & ready are both high at a rising clk edge.
  - dout.valid does not depend on dout.ready.
  - Once dout.valid is high, dout.valid and dout.data hold stable until the transfer.
- Reset (rst == 0 at a clk edge)
  - state = ACC, cnt = 0, acc = 0.
  - dout.valid = 0, dout.data = 0.
  - Any in-progress group is discarded; a pending unread output is dropped.
  - din.ready is 0 while rst is low.
- Extension
  - ext(din) = din.data extended to DOUT bits: sign-extended if DIN_SIGNED, else zero-extended.
  - Additions are modulo 2^DOUT; wrap silently unless ACCUM_SAT_EN is defined.
- State ACC (collecting)
  - din.ready = 1, dout.valid = 0.
  - On a din transfer with cnt < LEN-1: acc <= acc + ext(din), cnt <= cnt + 1.
  - On a din transfer with cnt == LEN-1: dout.data <= acc + ext(din), acc <= 0, cnt <= 0, go to OUT.
  - A cnt-0 transfer uses acc = 0, so the first element is loaded, not added.
- State OUT (holding result)
  - dout.valid = 1, din.ready = dout.ready.
  - dout transfer without din transfer: go to ACC.
  - dout transfer and din transfer in the same cycle:
    - The new element starts the next group: acc <= ext(din), cnt <= 1, go to ACC.
    - If LEN == 1: dout.data <= ext(din) and stay in OUT.
  - No dout transfer: din is stalled (ready = 0); all state holds.
- Throughput and latency
  - One sum per LEN cycles at full throughput, with no bubble between groups.
  - Latency: dout.valid rises the cycle after the LEN-th din transfer.
- LEN == 1: the block degenerates to a one-deep registered pipeline stage with full throughput.

Optional Feature:
- Macro: ACCUM_SAT_EN.
- Defined:
  - Each addition is computed at DOUT+1 bits.
  - On overflow the result clamps to the DOUT-bit extreme: 2^DOUT-1 when unsigned; 2^(DOUT-1)-1 or -2^(DOUT-1) when signed.
  - Clamping applies at every step, so saturation is sticky within a group.
  - Clamping is also applied to the value loaded into dout.data.
- Undefined: modulo-2^DOUT wraparound; no extra logic.

Test Plan:
1. Reset values: hold rst=0 for 3 cycles with din.valid=1 -> din.ready=0, dout.valid=0, dout.data=0; release rst -> din.ready=1 on the next cycle.
2. Basic sums: DIN=8, LEN=4, unsigned; din 1,2,3,4 then 10,20,30,40 back-to-back with dout.ready=1 -> dout 10 then 100; each dout.valid asserts the cycle after the 4th transfer; no stall cycles.
3. Backpressure: dout.ready=0 for 5 cycles after the first sum -> dout.data stays 10 and din.ready=0 throughout; on release, the same-cycle din transfer starts the next group and the next output is 100.
4. Signed input: DIN=8, DIN_SIGNED=1, LEN=2; din 0xFF,0xFE -> dout = -3 (DOUT=9, 0x1FD); the same values with DIN_SIGNED=0 -> 0x1FD = 509.
5. Overflow: DIN=8, LEN=4, DOUT=8, unsigned; din 200,100,0,0 -> without ACCUM_SAT_EN dout=44; with ACCUM_SAT_EN dout=255. Signed variant: din 100,100,-128,0 -> with ACCUM_SAT_EN dout=-1 (127 + -128); without it dout=72 (200 wraps to -56, -56 + -128 wraps to 72).
6. Mid-group reset and LEN=1: assert rst after 2 of 4 transfers -> the next group of 1,1,1,1 yields 4 (no residue). With LEN=1, a continuous din 5,6,7 and dout.ready=1 -> dout 5,6,7, one per cycle, after 1-cycle latency.

Source files
------------

// File: rtl/accum.sv
// accum: streaming accumulator behind the multiplier stage.
// Sums each group of LEN consecutive din transfers and presents one registered
// sum per group on dout (valid/ready on both sides, no bubble between groups).
// Optional build macro ACCUM_SAT_EN: clamp every addition to the DOUT-bit
// extreme instead of wrapping modulo 2^DOUT.
module accum #(
    parameter int DIN        = 16,
    parameter int DIN_SIGNED = 0,
    parameter int LEN        = 4,
    parameter int DOUT       = DIN + $clog2(LEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DIN-1:0]  din_data_i,
    input  logic            din_valid_i,
    output logic            din_ready_o,
    output logic [DOUT-1:0] dout_data_o,
    output logic            dout_valid_o,
    input  logic            dout_ready_i
);

    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);
`ifdef ACCUM_SAT_EN
    localparam logic [DOUT-1:0] SMAX = {1'b0, {(DOUT-1){1'b1}}};
`endif

    typedef enum logic {
        ST_ACC,
        ST_OUT
    } state_t;

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DOUT-1:0] acc_q, acc_d;
    logic [DOUT-1:0] dout_q, dout_d;
    logic [DOUT-1:0] ext;
    logic [DOUT-1:0] base;
    logic [DOUT-1:0] sum;
    logic            din_fire;
    logic            dout_fire;

    // One accumulation step; saturating build clamps to the representable range.
    function automatic logic [DOUT-1:0] add_step(input logic [DOUT-1:0] a,
                                                 input logic [DOUT-1:0] b);
`ifdef ACCUM_SAT_EN
        logic [DOUT:0] s;
        if (DIN_SIGNED != 0) begin
            s = {a[DOUT-1], a} + {b[DOUT-1], b};
            if (s[DOUT] != s[DOUT-1]) begin
                return s[DOUT] ? ~SMAX : SMAX;
            end
        end else begin
            s = {1'b0, a} + {1'b0, b};
            if (s[DOUT]) begin
                return '1;
            end
        end
        return s[DOUT-1:0];
`else
        return a + b;
`endif
    endfunction

    assign dout_valid_o = (state_q == ST_OUT);
    // While holding a result, input only moves when the result leaves.
    assign din_ready_o  = rst & ((state_q == ST_ACC) | dout_ready_i);
    assign dout_data_o  = dout_q;
    assign din_fire     = din_valid_i & din_ready_o;
    assign dout_fire    = dout_valid_o & dout_ready_i;

    // Widen the incoming product to the accumulator width.
    always_comb begin
        if (DIN_SIGNED != 0) begin
            ext = DOUT'($signed(din_data_i));
        end else begin
            ext = DOUT'(din_data_i);
        end
    end

    // Next-state: collect a group in ACC, hold the sum in OUT until taken.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        dout_d  = dout_q;
        // The first element of a group is loaded, not added to stale state.
        base    = (cnt_q == '0) ? '0 : acc_q;
        sum     = add_step(base, ext);
        case (state_q)
            ST_ACC: begin
                if (din_fire) begin
                    if (cnt_q == CNT_LAST) begin
                        dout_d  = sum;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_OUT;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_OUT: begin
                if (dout_fire) begin
                    if (din_fire) begin
                        if (LEN == 1) begin
                            // Single-element groups: the new element is the next result.
                            dout_d = ext;
                        end else begin
                            acc_d   = ext;
                            cnt_d   = CNT_W'(1);
                            state_d = ST_ACC;
                        end
                    end else begin
                        state_d = ST_ACC;
                    end
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_ACC;
            cnt_q   <= '0;
            acc_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            dout_q  <= dout_d;
        end
    end

endmodule

// File: tb/tb_accum.sv
// tb_accum: directed checks of accum across several parameter sets sharing
// one input stream; each scenario resets the DUTs before driving.
module tb_accum;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din_data;
    logic       din_valid;
    logic       dout_ready;

    logic       rdy0, rdy1, rdy2, rdy3, rdy4, rdy5;
    logic       vld0, vld1, vld2, vld3, vld4, vld5;
    logic [9:0] data0;
    logic [8:0] data1, data2;
    logic [7:0] data3, data4, data5;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    // LEN=4 unsigned, DOUT=10
    accum #(.DIN(8), .DIN_SIGNED(0), .LEN(4)) u0 (
        .clk(clk), .rst(rst), .din_data_i(din_data), .din_valid_i(din_valid),
        .din_ready_o(rdy0), .dout_data_o(data0), .dout_valid_o(vld0), .dout_ready_i(dout_ready));
    // LEN=2 signed, DOUT=9
    accum #(.DIN(8), .DIN_SIGNED(1), .LEN(2)) u1 (
        .clk(clk), .rst(rst), .din_data_i(din_data), .din_valid_i(din_valid),
        .din_ready_o(rdy1), .dout_data_o(data1), .dout_valid_o(vld1), .dout_ready_i(dout_ready));
    // LEN=2 unsigned, DOUT=9
    accum #(.DIN(8), .DIN_SIGNED(0), .LEN(2)) u2 (
        .clk(clk), .rst(rst), .din_data_i(din_data), .din_valid_i(din_valid),
        .din_ready_o(rdy2), .dout_data_o(data2), .dout_valid_o(vld2), .dout_ready_i(dout_ready));
    // LEN=4 unsigned, narrow DOUT=8
    accum #(.DIN(8), .DIN_SIGNED(0), .LEN(4), .DOUT(8)) u3 (
        .clk(clk), .rst(rst), .din_data_i(din_data), .din_valid_i(din_valid),
        .din_ready_o(rdy3), .dout_data_o(data3), .dout_valid_o(vld3), .dout_ready_i(dout_ready));
    // LEN=4 signed, narrow DOUT=8
    accum #(.DIN(8), .DIN_SIGNED(1), .LEN(4), .DOUT(8)) u4 (
        .clk(clk), .rst(rst), .din_data_i(din_data), .din_valid_i(din_valid),
        .din_ready_o(rdy4), .dout_data_o(data4), .dout_valid_o(vld4), .dout_ready_i(dout_ready));
    // LEN=1 pipeline stage, DOUT=8
    accum #(.DIN(8), .DIN_SIGNED(0), .LEN(1)) u5 (
        .clk(clk), .rst(rst), .din_data_i(din_data), .din_valid_i(din_valid),
        .din_ready_o(rdy5), .dout_data_o(data5), .dout_valid_o(vld5), .dout_ready_i(dout_ready));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic do_reset;
        tick;
        rst = 1'b0;
        din_valid = 1'b0;
        dout_ready = 1'b1;
        tick;
        rst = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        din_valid = 1'b1;
        din_data = 8'h55;
        dout_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            settle;
            nvec++;
            if (rdy0 !== 1'b0 || vld0 !== 1'b0 || data0 !== 10'd0) begin
                nerr++;
                $display("FAIL reset_hold cyc%0d: ready=%b valid=%b data=%0d, want 0 0 0", i, rdy0, vld0, data0);
            end
        end
        tick;
        rst = 1'b1;
        din_valid = 1'b0;
        settle;
        nvec++;
        if (rdy0 !== 1'b1 || vld0 !== 1'b0) begin
            nerr++;
            $display("FAIL reset_release: ready=%b valid=%b, want 1 0", rdy0, vld0);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic_sums;
        logic [7:0] vals [8] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd10, 8'd20, 8'd30, 8'd40};
        do_reset;
        dout_ready = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            tick;
            if (k < 8) begin
                din_valid = 1'b1;
                din_data = vals[k];
            end else begin
                din_valid = 1'b0;
            end
            settle;
            nvec++;
            if (vld0 !== ((k == 4) || (k == 8))) begin
                nerr++;
                $display("FAIL basic_valid k%0d: valid=%b want %b", k, vld0, (k == 4) || (k == 8));
            end
            nvec++;
            if (rdy0 !== 1'b1) begin
                nerr++;
                $display("FAIL basic_ready k%0d: ready=%b want 1", k, rdy0);
            end
            if (k == 4) begin
                nvec++;
                if (data0 !== 10'd10) begin
                    nerr++;
                    $display("FAIL basic_sum1: data=%0d want 10", data0);
                end
            end
            if (k == 8) begin
                nvec++;
                if (data0 !== 10'd100) begin
                    nerr++;
                    $display("FAIL basic_sum2: data=%0d want 100", data0);
                end
            end
        end
        $display("test_basic_sums done");
    endtask

    task automatic test_backpressure;
        logic [7:0] head [4] = '{8'd1, 8'd2, 8'd3, 8'd4};
        logic [7:0] tail [3] = '{8'd20, 8'd30, 8'd40};
        do_reset;
        dout_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick;
            din_valid = 1'b1;
            din_data = head[k];
        end
        for (int k = 0; k < 5; k++) begin
            tick;
            din_data = 8'd10;
            dout_ready = 1'b0;
            settle;
            nvec++;
            if (rdy0 !== 1'b0 || vld0 !== 1'b1 || data0 !== 10'd10) begin
                nerr++;
                $display("FAIL bp_stall c%0d: ready=%b valid=%b data=%0d, want 0 1 10", k, rdy0, vld0, data0);
            end
        end
        tick;
        dout_ready = 1'b1;
        settle;
        nvec++;
        if (rdy0 !== 1'b1 || vld0 !== 1'b1 || data0 !== 10'd10) begin
            nerr++;
            $display("FAIL bp_release: ready=%b valid=%b data=%0d, want 1 1 10", rdy0, vld0, data0);
        end
        for (int k = 0; k < 3; k++) begin
            tick;
            din_data = tail[k];
            settle;
            nvec++;
            if (vld0 !== 1'b0) begin
                nerr++;
                $display("FAIL bp_collect c%0d: valid=%b want 0", k, vld0);
            end
        end
        tick;
        din_valid = 1'b0;
        settle;
        nvec++;
        if (vld0 !== 1'b1 || data0 !== 10'd100) begin
            nerr++;
            $display("FAIL bp_sum2: valid=%b data=%0d, want 1 100", vld0, data0);
        end
        $display("test_backpressure done");
    endtask

    task automatic test_signed;
        logic [7:0] vals [4] = '{8'hFF, 8'hFE, 8'h80, 8'h01};
        do_reset;
        dout_ready = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            tick;
            if (k < 4) begin
                din_valid = 1'b1;
                din_data = vals[k];
            end else begin
                din_valid = 1'b0;
            end
            settle;
            if (k == 2) begin
                nvec++;
                if (vld1 !== 1'b1 || data1 !== 9'h1FD) begin
                    nerr++;
                    $display("FAIL signed_ff_fe: valid=%b data=%h, want 1 1fd", vld1, data1);
                end
                nvec++;
                if (vld2 !== 1'b1 || data2 !== 9'h1FD) begin
                    nerr++;
                    $display("FAIL unsigned_ff_fe: valid=%b data=%h, want 1 1fd", vld2, data2);
                end
            end
            if (k == 4) begin
                nvec++;
                if (vld1 !== 1'b1 || data1 !== 9'h181) begin
                    nerr++;
                    $display("FAIL signed_80_01: valid=%b data=%h, want 1 181", vld1, data1);
                end
                nvec++;
                if (vld2 !== 1'b1 || data2 !== 9'h081) begin
                    nerr++;
                    $display("FAIL unsigned_80_01: valid=%b data=%h, want 1 081", vld2, data2);
                end
            end
        end
        $display("test_signed done");
    endtask

    task automatic test_overflow;
        logic [7:0] uvals [4] = '{8'd200, 8'd100, 8'd0, 8'd0};
        logic [7:0] svals [4] = '{8'd100, 8'd100, 8'h80, 8'd0};
        logic [7:0] exp_u1, exp_s, exp_u2;
`ifdef ACCUM_SAT_EN
        exp_u1 = 8'd255;
        exp_s  = 8'hFF;
        exp_u2 = 8'd255;
`else
        exp_u1 = 8'd44;
        exp_s  = 8'd72;
        exp_u2 = 8'd72;
`endif
        do_reset;
        dout_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick;
            din_valid = 1'b1;
            din_data = uvals[k];
        end
        tick;
        din_valid = 1'b0;
        settle;
        nvec++;
        if (vld3 !== 1'b1 || data3 !== exp_u1) begin
            nerr++;
            $display("FAIL ovf_unsigned: valid=%b data=%0d, want 1 %0d", vld3, data3, exp_u1);
        end
        do_reset;
        for (int k = 0; k < 4; k++) begin
            tick;
            din_valid = 1'b1;
            din_data = svals[k];
        end
        tick;
        din_valid = 1'b0;
        settle;
        nvec++;
        if (vld4 !== 1'b1 || data4 !== exp_s) begin
            nerr++;
            $display("FAIL ovf_signed: valid=%b data=%h, want 1 %h", vld4, data4, exp_s);
        end
        nvec++;
        if (vld3 !== 1'b1 || data3 !== exp_u2) begin
            nerr++;
            $display("FAIL ovf_unsigned2: valid=%b data=%0d, want 1 %0d", vld3, data3, exp_u2);
        end
        $display("test_overflow done");
    endtask

    task automatic test_midreset_len1;
        logic [7:0] pvals [3] = '{8'd5, 8'd6, 8'd7};
        do_reset;
        dout_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick;
            din_valid = 1'b1;
            din_data = 8'd1;
        end
        do_reset;
        for (int k = 0; k < 4; k++) begin
            tick;
            din_valid = 1'b1;
            din_data = 8'd1;
        end
        tick;
        din_valid = 1'b0;
        settle;
        nvec++;
        if (vld0 !== 1'b1 || data0 !== 10'd4) begin
            nerr++;
            $display("FAIL midreset_sum: valid=%b data=%0d, want 1 4", vld0, data0);
        end
        do_reset;
        for (int k = 0; k <= 4; k++) begin
            tick;
            if (k < 3) begin
                din_valid = 1'b1;
                din_data = pvals[k];
            end else begin
                din_valid = 1'b0;
            end
            settle;
            nvec++;
            if (vld5 !== ((k >= 1) && (k <= 3))) begin
                nerr++;
                $display("FAIL len1_valid k%0d: valid=%b want %b", k, vld5, (k >= 1) && (k <= 3));
            end
            nvec++;
            if (rdy5 !== 1'b1) begin
                nerr++;
                $display("FAIL len1_ready k%0d: ready=%b want 1", k, rdy5);
            end
            if (k >= 1 && k <= 3) begin
                nvec++;
                if (data5 !== pvals[k-1]) begin
                    nerr++;
                    $display("FAIL len1_data k%0d: data=%0d want %0d", k, data5, pvals[k-1]);
                end
            end
        end
        $display("test_midreset_len1 done");
    endtask

    initial begin
        rst = 1'b0;
        din_valid = 1'b0;
        din_data = 8'd0;
        dout_ready = 1'b1;
        test_reset;
        test_basic_sums;
        test_backpressure;
        test_signed;
        test_overflow;
        test_midreset_len1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
